// File: rtl/instr_encoder.sv
// instr_encoder: streaming RV32I-subset instruction encoder.
// Symbolic instructions in (valid/ready), 32-bit machine words out with the
// byte PC each word will occupy. Branch/jump targets arrive as absolute byte
// addresses and are turned into PC-relative offsets here.
// Optional range checking is built when ENCODER_RANGE_CHECK_EN is defined;
// otherwise err_range is tied to 0.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        err_illegal,
  output logic        err_range
);

  // Symbolic op codes as seen on in_op.
  localparam logic [3:0] OP_ADDI = 4'd0;
  localparam logic [3:0] OP_XORI = 4'd1;
  localparam logic [3:0] OP_ORI  = 4'd2;
  localparam logic [3:0] OP_ANDI = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_AND  = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_BEQ  = 4'd9;
  localparam logic [3:0] OP_BNE  = 4'd10;
  localparam logic [3:0] OP_JAL  = 4'd11;
  localparam logic [3:0] OP_JALR = 4'd12;

  // Major opcodes.
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_I,
    FMT_R,
    FMT_S,
    FMT_B,
    FMT_J,
    FMT_NOP
  } fmt_e;

  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } enc_req_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } enc_rsp_t;

  enc_req_t          req;
  enc_rsp_t          rsp;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       cur_pc;
  logic [31:0]       rel_off;
  logic              hs_in;
  logic              hs_out;

  fmt_e              fmt;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic              illegal;
  logic [31:0]       word;

  assign req = '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};

  // The PC window is 2^ADDR_W words above BASE_ADDR; idx wraps naturally.
  assign cur_pc  = BASE_ADDR + 32'({idx, 2'b00});
  assign rel_off = req.imm - cur_pc;

  assign in_ready = !out_valid || out_ready;
  assign hs_in    = in_valid && in_ready;
  assign hs_out   = out_valid && out_ready;

  // Classify the op: instruction format, major opcode and funct3.
  always_comb begin
    fmt     = FMT_NOP;
    opcode  = OPC_OPIMM;
    funct3  = 3'b000;
    illegal = 1'b0;
    case (req.op)
      OP_ADDI: begin fmt = FMT_I; opcode = OPC_OPIMM;  funct3 = 3'b000; end
      OP_XORI: begin fmt = FMT_I; opcode = OPC_OPIMM;  funct3 = 3'b100; end
      OP_ORI:  begin fmt = FMT_I; opcode = OPC_OPIMM;  funct3 = 3'b110; end
      OP_ANDI: begin fmt = FMT_I; opcode = OPC_OPIMM;  funct3 = 3'b111; end
      OP_ADD:  begin fmt = FMT_R; opcode = OPC_OP;     funct3 = 3'b000; end
      OP_XOR:  begin fmt = FMT_R; opcode = OPC_OP;     funct3 = 3'b100; end
      OP_OR:   begin fmt = FMT_R; opcode = OPC_OP;     funct3 = 3'b110; end
      OP_AND:  begin fmt = FMT_R; opcode = OPC_OP;     funct3 = 3'b111; end
      OP_SW:   begin fmt = FMT_S; opcode = OPC_STORE;  funct3 = 3'b010; end
      OP_BEQ:  begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = 3'b000; end
      OP_BNE:  begin fmt = FMT_B; opcode = OPC_BRANCH; funct3 = 3'b001; end
      OP_JAL:  begin fmt = FMT_J; opcode = OPC_JAL;    funct3 = 3'b000; end
      OP_JALR: begin fmt = FMT_I; opcode = OPC_JALR;   funct3 = 3'b000; end
      default: begin fmt = FMT_NOP; illegal = 1'b1; end
    endcase
  end

  // Pack fields into the 32-bit word; immediates are simply truncated.
  always_comb begin
    word = NOP_WORD;
    case (fmt)
      FMT_I: word = {req.imm[11:0], req.rs1, funct3, req.rd, opcode};
      FMT_R: word = {7'b0000000, req.rs2, req.rs1, funct3, req.rd, opcode};
      FMT_S: word = {req.imm[11:5], req.rs2, req.rs1, funct3, req.imm[4:0], opcode};
      FMT_B: word = {rel_off[12], rel_off[10:5], req.rs2, req.rs1, funct3,
                     rel_off[4:1], rel_off[11], opcode};
      FMT_J: word = {rel_off[20], rel_off[10:1], rel_off[11], rel_off[19:12],
                     req.rd, opcode};
      default: word = NOP_WORD;
    endcase
  end

  // Output stage, PC index and illegal flag; rst beats flush beats handshakes.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_valid   <= 1'b0;
      rsp         <= '{instr: 32'h0, pc: BASE_ADDR};
      idx         <= '0;
      err_illegal <= 1'b0;
    end else if (hs_in) begin
      out_valid   <= 1'b1;
      rsp         <= '{instr: word, pc: cur_pc};
      idx         <= idx + ADDR_W'(1);
      if (illegal) err_illegal <= 1'b1;
    end else if (hs_out) begin
      out_valid   <= 1'b0;
    end
  end

  assign out_instr = rsp.instr;
  assign out_pc    = rsp.pc;

`ifdef ENCODER_RANGE_CHECK_EN
  logic imm_ok;
  logic b_ok;
  logic j_ok;
  logic range_bad;

  // A value fits a signed field when all bits above the field's sign bit
  // equal that sign bit.
  assign imm_ok = (&req.imm[31:11]) || !(|req.imm[31:11]);
  assign b_ok   = ((&rel_off[31:12]) || !(|rel_off[31:12])) && !rel_off[0];
  assign j_ok   = ((&rel_off[31:20]) || !(|rel_off[31:20])) && !rel_off[0];

  // Select the check that applies to this op's format.
  always_comb begin
    range_bad = 1'b0;
    case (fmt)
      FMT_I, FMT_S: range_bad = !imm_ok;
      FMT_B:        range_bad = !b_ok;
      FMT_J:        range_bad = !j_ok;
      default:      range_bad = 1'b0;
    endcase
  end

  // Sticky range flag, set on the edge that accepts the offending input.
  always_ff @(posedge clk) begin
    if (rst || flush)
      err_range <= 1'b0;
    else if (hs_in && range_bad)
      err_range <= 1'b1;
  end
`else
  assign err_range = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder with a reference model
// built from the ISA field layout using shifts/masks and a scoreboard queue.
module tb_instr_encoder;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam int          AW   = 2;

`ifdef ENCODER_RANGE_CHECK_EN
  localparam logic RNG_EN = 1'b1;
`else
  localparam logic RNG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr, out_pc;
  logic        err_illegal, err_range;

  int total = 0;
  int bad   = 0;

  instr_encoder #(.BASE_ADDR(BASE), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc),
    .err_illegal(err_illegal), .err_range(err_range)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] instr; logic [31:0] pc; } exp_t;
  exp_t        sb[$];
  int          m_cnt = 0;
  logic        m_ill = 0, m_rng = 0;

  function automatic logic [31:0] ref_word(input logic [3:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
      input logic [31:0] pc);
    logic [31:0] r, off, f3;
    logic [31:0] tbl_f3 [4];
    tbl_f3[0] = 0; tbl_f3[1] = 4; tbl_f3[2] = 6; tbl_f3[3] = 7;
    off = imm - pc;
    r = 32'h13;
    if (op <= 3)
      r = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (tbl_f3[op[1:0]] << 12) | (32'(rd) << 7) | 32'h13;
    else if (op <= 7)
      r = (32'(rs2) << 20) | (32'(rs1) << 15) | (tbl_f3[op[1:0]] << 12) | (32'(rd) << 7) | 32'h33;
    else if (op == 8)
      r = (((imm >> 5) & 127) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | (32'd2 << 12) | ((imm & 31) << 7) | 32'h23;
    else if (op == 9 || op == 10) begin
      f3 = (op == 10) ? 32'd1 : 32'd0;
      r = (((off >> 12) & 1) << 31) | (((off >> 5) & 63) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
        | (f3 << 12) | (((off >> 1) & 15) << 8) | (((off >> 11) & 1) << 7) | 32'h63;
    end else if (op == 11)
      r = (((off >> 20) & 1) << 31) | (((off >> 1) & 1023) << 21) | (((off >> 11) & 1) << 20)
        | (((off >> 12) & 255) << 12) | (32'(rd) << 7) | 32'h6F;
    else if (op == 12)
      r = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(rd) << 7) | 32'h67;
    return r;
  endfunction

  function automatic logic ref_range_bad(input logic [3:0] op, input logic [31:0] imm,
                                         input logic [31:0] pc);
    int signed si, so;
    si = $signed(imm);
    so = $signed(imm - pc);
    if (op <= 3 || op == 8 || op == 12) return (si < -2048) || (si > 2047);
    if (op == 9 || op == 10) return (so < -4096) || (so > 4094) || (so % 2 != 0);
    if (op == 11) return (so < -1048576) || (so > 1048574) || (so % 2 != 0);
    return 1'b0;
  endfunction

  // ---------------- monitor / scoreboard (samples on negedge) ----------------
  logic        st_v = 0;
  logic [31:0] st_i, st_p;

  always @(negedge clk) begin
    exp_t e;
    logic [31:0] pc;
    if (rst || flush) begin
      sb.delete();
      m_cnt = 0; m_ill = 0; m_rng = 0; st_v = 0;
    end else begin
      chk("err_illegal", 32'(err_illegal), 32'(m_ill));
      chk("err_range", 32'(err_range), 32'(m_rng));
      if (st_v) begin
        chk("hold_instr", out_instr, st_i);
        chk("hold_pc", out_pc, st_p);
      end
      st_v = out_valid && !out_ready;
      st_i = out_instr; st_p = out_pc;
      if (st_v) chk("stall_in_ready", 32'(in_ready), 32'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_word", out_instr, 32'hxxxx_xxxx);
        else begin
          e = sb.pop_front();
          chk("word", out_instr, e.instr);
          chk("pc", out_pc, e.pc);
        end
      end
      if (in_valid && in_ready) begin
        pc = BASE + 32'(4 * m_cnt);
        e.instr = ref_word(in_op, in_rd, in_rs1, in_rs2, in_imm, pc);
        e.pc = pc;
        sb.push_back(e);
        m_cnt = (m_cnt + 1) % (1 << AW);
        if (in_op >= 13) m_ill = 1;
        if (RNG_EN && ref_range_bad(in_op, in_imm, pc)) m_rng = 1;
      end
    end
  end

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm);
    int n = 0;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_pc", out_pc, BASE);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_flags", {30'd0, err_illegal, err_range}, 32'd0);

    // ADDI x1, x0, 5
    send(4'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_word", out_instr, 32'h0050_0093);
    chk("addi_pc", out_pc, BASE);

    // ADD then SW, back-to-back from a fresh index
    do_flush();
    send(4'd4, 5'd3, 5'd1, 5'd2, 32'd0);
    chk("add_word", out_instr, 32'h0020_81B3);
    chk("add_pc", out_pc, BASE);
    send(4'd8, 5'd0, 5'd1, 5'd2, 32'd8);
    chk("sw_word", out_instr, 32'h0020_A423);
    chk("sw_pc", out_pc, BASE + 4);
    // filler at +8, then BEQ at +12 targeting +8
    send(4'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    send(4'd9, 5'd0, 5'd1, 5'd2, BASE + 8);
    chk("beq_word", out_instr, 32'hFE20_8EE3);
    chk("beq_pc", out_pc, BASE + 12);
    // fifth input wraps to BASE: JAL x1 to +8
    send(4'd11, 5'd1, 5'd0, 5'd0, BASE + 8);
    chk("jal_word", out_instr, 32'h0080_00EF);
    chk("wrap_pc", out_pc, BASE);

    // illegal op
    send(4'd14, 5'd0, 5'd0, 5'd0, 32'd0);
    chk("ill_word", out_instr, 32'h0000_0013);
    chk("ill_pc", out_pc, BASE + 4);
    chk("ill_flag", 32'(err_illegal), 32'd1);
    do_flush();
    chk("flush_ill", 32'(err_illegal), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    send(4'd1, 5'd4, 5'd5, 5'd0, 32'hFFFF_FFFF);
    chk("flush_pc", out_pc, BASE);

    // range checks
    do_flush();
    send(4'd0, 5'd1, 5'd0, 5'd0, 32'd4096);
    chk("rng_imm", 32'(err_range), 32'(RNG_EN));
    do_flush();
    send(4'd9, 5'd0, 5'd1, 5'd2, BASE + 9);
    chk("rng_odd", 32'(err_range), 32'(RNG_EN));

    // backpressure: hold out_ready low 3 cycles with a word pending
    do_flush();
    send(4'd5, 5'd7, 5'd8, 5'd9, 32'd0);
    out_ready = 1'b0;
    in_op = 4'd2; in_rd = 5'd10; in_rs1 = 5'd11; in_imm = 32'h0000_07FF; in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; chk("bp_in_ready", 32'(in_ready), 32'd0); end
    in_valid = 1'b0;
    out_ready = 1'b1;
    send(4'd6, 5'd1, 5'd2, 5'd3, 32'd0);
    send(4'd7, 5'd4, 5'd5, 5'd6, 32'd0);
    send(4'd12, 5'd1, 5'd2, 5'd0, 32'hFFFF_F800);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      flush     = ($urandom_range(0, 59) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = 4'($urandom_range(0, 15));
      in_rd     = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      case ($urandom_range(0, 3))
        0: in_imm = $urandom;
        1: in_imm = 32'($urandom_range(0, 4095)) - 32'd2048;
        2: in_imm = BASE + 32'($urandom_range(0, 40));
        default: in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      endcase
      @(posedge clk); #1;
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

    // drain
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 20) begin @(posedge clk); #1; n++; end
    chk("drain_left", 32'(sb.size()), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
